// File: rtl/scr1_dmi_arb.sv
// scr1_dmi_arb: two-port round-robin arbiter and sequencer for the single Debug Module DMI port.
//   clk, rst          : clock, synchronous active-high reset
//   req_i/wr_i        : per-port request (held until gnt_o) and write flag
//   addr_i/wdata_i    : per-port payload, sampled on the granting edge
//   gnt_o             : combinational one-hot accept (IDLE only)
//   resp_o/err_o      : one-cycle completion pulse to the owner, err_o=1 on timeout
//   rdata_o           : read data with resp_o, 0 for writes and timeouts
//   dmi_req..dmi_wdata: registered DM request, stable while BUSY
//   dmi_resp/dmi_rdata: DM response strobe and read data
module scr1_dmi_arb #(
    parameter int TIMEOUT                 = 255,
    parameter int SCR1_DBG_DMI_ADDR_WIDTH = 7,
    parameter int SCR1_DBG_DMI_DATA_WIDTH = 32
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [1:0]                                   req_i,
    input  logic [1:0]                                   wr_i,
    input  logic [1:0][SCR1_DBG_DMI_ADDR_WIDTH-1:0]      addr_i,
    input  logic [1:0][SCR1_DBG_DMI_DATA_WIDTH-1:0]      wdata_i,
    output logic [1:0]                                   gnt_o,
    output logic [1:0]                                   resp_o,
    output logic                                         err_o,
    output logic [SCR1_DBG_DMI_DATA_WIDTH-1:0]           rdata_o,
    output logic                                         dmi_req,
    output logic                                         dmi_wr,
    output logic [SCR1_DBG_DMI_ADDR_WIDTH-1:0]           dmi_addr,
    output logic [SCR1_DBG_DMI_DATA_WIDTH-1:0]           dmi_wdata,
    input  logic                                         dmi_resp,
    input  logic [SCR1_DBG_DMI_DATA_WIDTH-1:0]           dmi_rdata
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e                              state_q;
    logic                                last_q;
    logic                                owner_q;
    logic [CW-1:0]                       cnt_q;
    logic [CW-1:0]                       cnt_d;
    logic                                dmi_req_q;
    logic                                dmi_wr_q;
    logic [SCR1_DBG_DMI_ADDR_WIDTH-1:0]  dmi_addr_q;
    logic [SCR1_DBG_DMI_DATA_WIDTH-1:0]  dmi_wdata_q;
    logic [1:0]                          resp_q;
    logic                                err_q;
    logic [SCR1_DBG_DMI_DATA_WIDTH-1:0]  rdata_q;
    logic                                win;
    logic                                expire;

    // Under contention the port that did not win last time goes first.
    assign win    = &req_i ? ~last_q : req_i[1];
    assign gnt_o  = (state_q == IDLE && |req_i) ? (win ? 2'b10 : 2'b01) : 2'b00;
    assign cnt_d  = cnt_q + CW'(1);
    // Counter reads TIMEOUT-1 in the last BUSY cycle the DM is allowed.
    assign expire = (TIMEOUT != 0) && (cnt_q == LAST_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            owner_q     <= 1'b0;
            cnt_q       <= '0;
            dmi_req_q   <= 1'b0;
            dmi_wr_q    <= 1'b0;
            dmi_addr_q  <= '0;
            dmi_wdata_q <= '0;
            resp_q      <= 2'b00;
            err_q       <= 1'b0;
            rdata_q     <= '0;
        end else begin
            resp_q  <= 2'b00;
            err_q   <= 1'b0;
            rdata_q <= '0;
            case (state_q)
                IDLE: begin
                    if (|req_i) begin
                        state_q     <= BUSY;
                        owner_q     <= win;
                        last_q      <= win;
                        cnt_q       <= '0;
                        dmi_req_q   <= 1'b1;
                        dmi_wr_q    <= wr_i[win];
                        dmi_addr_q  <= addr_i[win];
                        dmi_wdata_q <= wdata_i[win];
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_d;
                    // A response in the expiry cycle still counts as success.
                    if (dmi_resp || expire) begin
                        state_q   <= IDLE;
                        dmi_req_q <= 1'b0;
                        resp_q    <= owner_q ? 2'b10 : 2'b01;
                        err_q     <= ~dmi_resp;
                        rdata_q   <= (dmi_resp && !dmi_wr_q) ? dmi_rdata : '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign resp_o    = resp_q;
    assign err_o     = err_q;
    assign rdata_o   = rdata_q;
    assign dmi_req   = dmi_req_q;
    assign dmi_wr    = dmi_wr_q;
    assign dmi_addr  = dmi_addr_q;
    assign dmi_wdata = dmi_wdata_q;
endmodule

// File: tb/tb_scr1_dmi_arb.sv
// tb_scr1_dmi_arb: directed stimulus with a transaction-level model checked every cycle.
module tb_scr1_dmi_arb;
    localparam int TO = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       req = 2'b00;
    logic [1:0]       wr = 2'b00;
    logic [1:0][6:0]  addr = '0;
    logic [1:0][31:0] wdata = '0;
    logic             dmi_resp = 1'b0;
    logic [31:0]      dmi_rdata = '0;
    logic [1:0]       gnt_o;
    logic [1:0]       resp_o;
    logic             err_o;
    logic [31:0]      rdata_o;
    logic             dmi_req;
    logic             dmi_wr;
    logic [6:0]       dmi_addr;
    logic [31:0]      dmi_wdata;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    scr1_dmi_arb #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req_i(req), .wr_i(wr), .addr_i(addr), .wdata_i(wdata),
        .gnt_o(gnt_o), .resp_o(resp_o), .err_o(err_o), .rdata_o(rdata_o),
        .dmi_req(dmi_req), .dmi_wr(dmi_wr), .dmi_addr(dmi_addr), .dmi_wdata(dmi_wdata),
        .dmi_resp(dmi_resp), .dmi_rdata(dmi_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a transaction is open from the grant edge until a response or
    // TO busy cycles have elapsed; m_age counts busy cycles including the current one.
    bit          m_busy = 1'b0;
    bit          m_last = 1'b1;
    bit          m_owner = 1'b0;
    int          m_age = 0;
    bit          e_req = 1'b0;
    bit          e_wr = 1'b0;
    logic [6:0]  e_addr = '0;
    logic [31:0] e_wdata = '0;
    logic [1:0]  e_resp = '0;
    bit          e_err = 1'b0;
    logic [31:0] e_rdata = '0;

    function automatic bit pick(input logic [1:0] r, input bit last);
        return (r == 2'b11) ? !last : r[1];
    endfunction

    always @(posedge clk) begin
        chk_en  <= 1'b1;
        e_resp  <= 2'b00;
        e_err   <= 1'b0;
        e_rdata <= '0;
        if (rst) begin
            m_busy  <= 1'b0;
            m_last  <= 1'b1;
            e_req   <= 1'b0;
            e_wr    <= 1'b0;
            e_addr  <= '0;
            e_wdata <= '0;
        end else if (!m_busy) begin
            if (req != 2'b00) begin
                m_busy  <= 1'b1;
                m_last  <= pick(req, m_last);
                m_owner <= pick(req, m_last);
                m_age   <= 1;
                e_req   <= 1'b1;
                e_wr    <= wr[pick(req, m_last)];
                e_addr  <= addr[pick(req, m_last)];
                e_wdata <= wdata[pick(req, m_last)];
            end
        end else if (dmi_resp || m_age == TO) begin
            m_busy  <= 1'b0;
            e_req   <= 1'b0;
            e_resp  <= 2'(1 << m_owner);
            e_err   <= !dmi_resp;
            e_rdata <= (dmi_resp && !e_wr) ? dmi_rdata : 32'h0;
        end else begin
            m_age <= m_age + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("gnt", 32'(gnt_o), (!m_busy && req != 2'b00) ? 32'(1 << pick(req, m_last)) : 32'h0);
            check("dmi_req", 32'(dmi_req), 32'(e_req));
            check("resp", 32'(resp_o), 32'(e_resp));
            check("err", 32'(err_o), 32'(e_err));
            check("rdata", rdata_o, e_rdata);
            if (e_req) begin
                check("dmi_wr", 32'(dmi_wr), 32'(e_wr));
                check("dmi_addr", 32'(dmi_addr), 32'(e_addr));
                check("dmi_wdata", dmi_wdata, e_wdata);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tick();
        tick();
        check("rst_dmi_req", 32'(dmi_req), 32'h0);
        check("rst_resp", 32'(resp_o), 32'h0);
        check("rst_rdata", rdata_o, 32'h0);
        rst = 1'b0;
        tick();

        // Contention with immediate responses: grants 0,1,0,1 then the leftover port 0.
        for (int k = 0; k < 4; k++) begin
            req = 2'b11;
            wr = 2'b00;
            addr[0] = 7'(k);
            addr[1] = 7'(k + 8);
            #1;
            check("cont_gnt", 32'(gnt_o), (k % 2 == 0) ? 32'h1 : 32'h2);
            tick();
            req[k % 2] = 1'b0;
            dmi_resp = 1'b1;
            dmi_rdata = 32'hA000_0000 + 32'(k);
            tick();
            dmi_resp = 1'b0;
            check("cont_resp", 32'(resp_o), (k % 2 == 0) ? 32'h1 : 32'h2);
            check("cont_rdata", rdata_o, 32'hA000_0000 + 32'(k));
        end
        #1;
        check("cont_tail_gnt", 32'(gnt_o), 32'h1);
        tick();
        req = 2'b00;
        dmi_resp = 1'b1;
        tick();
        dmi_resp = 1'b0;
        tick();

        // Stray response while idle is ignored.
        dmi_resp = 1'b1;
        dmi_rdata = 32'h5555_AAAA;
        tick();
        dmi_resp = 1'b0;
        check("idle_resp_ignored", 32'(resp_o), 32'h0);
        tick();

        // Single read, port 0, DM answers in the third busy cycle.
        req = 2'b01;
        wr = 2'b00;
        addr[0] = 7'h11;
        #1;
        check("rd_gnt", 32'(gnt_o), 32'h1);
        tick();
        req = 2'b00;
        check("rd_addr", 32'(dmi_addr), 32'h11);
        check("rd_wr", 32'(dmi_wr), 32'h0);
        tick();
        tick();
        dmi_resp = 1'b1;
        dmi_rdata = 32'hDEAD_BEEF;
        tick();
        dmi_resp = 1'b0;
        check("rd_resp", 32'(resp_o), 32'h1);
        check("rd_rdata", rdata_o, 32'hDEAD_BEEF);
        check("rd_err", 32'(err_o), 32'h0);
        check("rd_req_low", 32'(dmi_req), 32'h0);
        tick();

        // Write, port 1, DM answers in the first busy cycle.
        req = 2'b10;
        wr = 2'b10;
        addr[1] = 7'h10;
        wdata[1] = 32'h1234_5678;
        #1;
        check("wr_gnt", 32'(gnt_o), 32'h2);
        tick();
        req = 2'b00;
        check("wr_dmi_wr", 32'(dmi_wr), 32'h1);
        check("wr_wdata", dmi_wdata, 32'h1234_5678);
        dmi_resp = 1'b1;
        dmi_rdata = 32'hFFFF_FFFF;
        tick();
        dmi_resp = 1'b0;
        check("wr_resp", 32'(resp_o), 32'h2);
        check("wr_rdata", rdata_o, 32'h0);
        tick();

        // Timeout, port 0: request stays up exactly TO cycles.
        req = 2'b01;
        wr = 2'b00;
        addr[0] = 7'h22;
        tick();
        req = 2'b00;
        for (int i = 0; i < TO; i++) begin
            check("to_req_high", 32'(dmi_req), 32'h1);
            tick();
        end
        check("to_req_low", 32'(dmi_req), 32'h0);
        check("to_resp", 32'(resp_o), 32'h1);
        check("to_err", 32'(err_o), 32'h1);
        check("to_rdata", rdata_o, 32'h0);

        // Next request proceeds normally straight out of the timeout.
        req = 2'b10;
        wr = 2'b00;
        addr[1] = 7'h33;
        #1;
        check("post_to_gnt", 32'(gnt_o), 32'h2);
        tick();
        req = 2'b00;
        dmi_resp = 1'b1;
        dmi_rdata = 32'h0BAD_F00D;
        tick();
        dmi_resp = 1'b0;
        check("post_to_resp", 32'(resp_o), 32'h2);
        check("post_to_err", 32'(err_o), 32'h0);
        tick();

        // Response in the expiry cycle wins over the timeout.
        req = 2'b10;
        addr[1] = 7'h44;
        tick();
        req = 2'b00;
        tick();
        tick();
        tick();
        dmi_resp = 1'b1;
        dmi_rdata = 32'hCAFE_F00D;
        tick();
        dmi_resp = 1'b0;
        check("exp_resp", 32'(resp_o), 32'h2);
        check("exp_err", 32'(err_o), 32'h0);
        check("exp_rdata", rdata_o, 32'hCAFE_F00D);
        tick();

        // Reset in the second busy cycle aborts silently.
        req = 2'b10;
        addr[1] = 7'h55;
        tick();
        req = 2'b00;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_req", 32'(dmi_req), 32'h0);
        check("rst_mid_resp", 32'(resp_o), 32'h0);
        check("rst_mid_addr", 32'(dmi_addr), 32'h0);
        tick();
        tick();
        req = 2'b11;
        #1;
        check("rst_cont_gnt", 32'(gnt_o), 32'h1);
        tick();
        req = 2'b10;
        dmi_resp = 1'b1;
        dmi_rdata = 32'h1;
        tick();
        dmi_resp = 1'b0;
        check("rst_cont_resp", 32'(resp_o), 32'h1);
        tick();
        req = 2'b00;
        dmi_resp = 1'b1;
        tick();
        dmi_resp = 1'b0;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/scr1_dmi_arb.md
# scr1_dmi_arb

Round-robin arbiter and transaction sequencer sharing the single Debug Module DMI port between two requesters. Port 0 is the TAP-side DTM path; port 1 is a system-side debug master. The arbiter grants one requester at a time and holds the DM request stable until the DM responds. It returns read data and status to the owning requester, and aborts with an error status if the DM does not respond within a programmable number of cycles.

## Interface
Parameters:
- TIMEOUT, default 255: maximum cycles in BUSY without `dmi_resp`; 0 disables the timeout.
- Derived: counter width CW = $clog2(TIMEOUT+1), minimum 1. Address width A = SCR1_DBG_DMI_ADDR_WIDTH. Data width D = SCR1_DBG_DMI_DATA_WIDTH.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  block clock
- rst  in  1  synchronous active-high reset
- req_i  in  2  per-port request; held high until the port's gnt_o
- wr_i  in  2  per-port write (1) / read (0)
- addr_i  in  2×A  per-port address
- wdata_i  in  2×D  per-port write data
- gnt_o  out  2  combinational accept; payload is sampled on this edge
- resp_o  out  2  one-cycle completion pulse to the owning port
- err_o  out  1  completion status, valid with resp_o; 1 = timeout
- rdata_o  out  D  read data, valid with resp_o; 0 for writes and on timeout
- dmi_req  out  1  registered DM request
- dmi_wr  out  1  registered DM write
- dmi_addr  out  A  registered DM address
- dmi_wdata  out  D  registered DM write data
- dmi_resp  in  1  DM response strobe
- dmi_rdata  in  D  DM read data, valid with dmi_resp

## Operation
- States: IDLE, BUSY.
- **IDLE**
  - If any req_i is high, assert gnt_o for exactly one winner in the same cycle.
  - On that edge: latch wr/addr/wdata into the dmi_* registers, set dmi_req=1, record owner, clear the counter, go to BUSY.
- **Arbitration**
  - A single requester always wins.
  - When both request, grant the port other than last_owner, then set last_owner to the winner.
  - last_owner resets to 1, so port 0 wins the first contention.
- **BUSY**
  - dmi_* outputs hold stable; gnt_o=0.
  - The counter increments each cycle.
  - On dmi_resp=1: next edge clears dmi_req, pulses resp_o[owner], sets err_o=0, sets rdata_o=dmi_rdata for reads (0 for writes), returns to IDLE.
  - On timeout (TIMEOUT≠0, counter==TIMEOUT-1, dmi_resp=0): next edge clears dmi_req, pulses resp_o[owner] with err_o=1 and rdata_o=0, returns to IDLE.
- **Simultaneous dmi_resp and timeout expiry:** the response wins; err_o=0.
- **After completion:** dmi_wr/dmi_addr/dmi_wdata may retain their values but are don't-care while dmi_req=0.
- **Requester rules:** a requester must not raise req_i again until its resp_o. The arbiter does not buffer a second request per port. dmi_resp seen while in IDLE is ignored.
- **Reset (any time, including mid-BUSY)**
  - Effect on the next edge: state=IDLE, last_owner=1, counter=0.
  - All outputs are 0: dmi_req, dmi_wr, dmi_addr, dmi_wdata, resp_o, err_o, rdata_o.
  - No resp_o is issued for an aborted transaction.

## Timing
- gnt_o: same cycle T as the winning req_i in IDLE.
- dmi_req: high from T+1.
- DM responds at cycle U ≥ T+1: resp_o/rdata_o valid in cycle U+1 for exactly one cycle; dmi_req low in U+1.
- IDLE in U+1 may grant a new request in U+1; its dmi_req rises at U+2. Minimum DM request spacing is one idle cycle.
- Timeout: with no response, dmi_req is high for exactly TIMEOUT cycles (T+1 … T+TIMEOUT). resp_o with err_o=1 pulses at T+TIMEOUT+1.
- resp_o, err_o, and rdata_o are registered; gnt_o is the only combinational output.

## Test plan
- **Single read, port 0:** addr=0x11, DM responds 3 cycles after dmi_req with rdata 0xDEADBEEF → dmi_addr=0x11 and dmi_wr=0 held for 3 cycles; resp_o=2'b01, rdata_o=0xDEADBEEF, err_o=0 in the following cycle.
- **Contention:** both ports request at the same time, repeatedly with immediate response → grants alternate 0,1,0,1; first grant to port 0 after reset; each resp_o goes only to its owner.
- **Write:** port 1 writes 0x12345678 to 0x10, DM responds in cycle 1 → dmi_wr=1 and dmi_wdata=0x12345678 for one cycle; resp_o=2'b10, rdata_o=0.
- **Timeout, TIMEOUT=4:** DM never responds → dmi_req high exactly 4 cycles, then resp_o pulse with err_o=1, rdata_o=0. Next request proceeds normally.
- **Response at expiry cycle, TIMEOUT=4:** dmi_resp arrives in the 4th BUSY cycle → err_o=0, rdata_o=dmi_rdata.
- **Reset mid-BUSY:** rst at BUSY cycle 2 → next cycle dmi_req=0, all outputs 0, no resp_o; next contention grants port 0.
